// File: rtl/mdu_iter.sv
// mdu_iter: iterative MIPS multiply/divide unit holding the HI/LO registers
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDOp,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_mul, acc_div, prod;
  logic [WIDTH-1:0] opb, abs_a, abs_b, quo, rem;
  logic [WIDTH:0] sum, diff;
  logic is_mul, sgn, sgn_r, dbz, accept, sgnd, last;
  assign accept = state == IDLE && Start;
  assign sgnd = !MDOp[0];
  assign abs_a = sgnd && A[WIDTH-1] ? -A : A;
  assign abs_b = sgnd && B[WIDTH-1] ? -B : B;
  assign last = cnt == CW'(WIDTH - 1);
  assign Busy = state != IDLE;
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & opb};
  assign acc_mul = {sum, acc[WIDTH-1:1]};
  assign diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
  assign acc_div = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign prod = sgn ? -acc : acc;
  assign quo = sgn ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem = sgn_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  always_comb begin
    state_n = accept && MDOp[2:1] == 2'b00 ? MUL :
              accept && MDOp[2:1] == 2'b01 ? DIV :
              (state == MUL || state == DIV) && last ? FIN :
              state == FIN ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      opb <= '0;
      is_mul <= 1'b0;
      sgn <= 1'b0;
      sgn_r <= 1'b0;
      dbz <= 1'b0;
      Done <= 1'b0;
      DivByZero <= 1'b0;
      HI <= '0;
      LO <= '0;
    end else begin
      state <= state_n;
      Done <= state == FIN;
      cnt <= state == MUL || state == DIV ? cnt + 1'b1 : '0;
      if (accept && !MDOp[2]) begin
        is_mul <= !MDOp[1];
        acc <= {{WIDTH{1'b0}}, MDOp[1] ? abs_a : abs_b};
        opb <= MDOp[1] ? abs_b : abs_a;
        sgn <= sgnd && (A[WIDTH-1] ^ B[WIDTH-1]);
        sgn_r <= sgnd && A[WIDTH-1];
        dbz <= B == '0;
        if (!MDOp[1]) DivByZero <= 1'b0;
      end else if (state == MUL) acc <= acc_mul;
      else if (state == DIV) acc <= acc_div;
      if (accept && MDOp == 3'b100) HI <= A;
      if (accept && MDOp == 3'b101) LO <= A;
      if (state == FIN && is_mul) {HI, LO} <= prod;
      if (state == FIN && !is_mul) DivByZero <= dbz;
      if (state == FIN && !is_mul && !dbz) begin
        HI <= rem;
        LO <= quo;
      end
    end
  end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed self-checking bench for mdu_iter
module tb_mdu_iter;
  logic clk, rst_n, Start, Busy, Done, DivByZero;
  logic [31:0] A, B, HI, LO;
  logic [2:0] MDOp;
  int n_cmp, n_err, lat, bsy;
  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDOp(MDOp), .Start(Start),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .HI(HI), .LO(LO)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    A = a;
    B = b;
    MDOp = op;
    Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    MDOp = 3'b111;
  endtask
  task automatic wait_done(output int l, output int bc);
    l = 0;
    bc = 0;
    while (!Done && l < 100) begin
      if (Busy) bc++;
      @(posedge clk);
      #1 l++;
    end
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_op(op, a, b);
    wait_done(lat, bsy);
  endtask
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    Start = 1'b0;
    A = '0;
    B = '0;
    MDOp = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_dbz", DivByZero, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_lat", lat, 33);
    check("multu_busy_cycles", bsy, 33);
    check("multu_busy_at_done", Busy, 0);
    check("multu_hi", HI, 32'hFFFFFFFE);
    check("multu_lo", LO, 32'h00000001);
    @(posedge clk);
    #1 check("done_one_cycle", Done, 0);
    run_op(3'b000, 32'hFFFFFFFD, 32'd5);
    check("mult_neg_lat", lat, 33);
    check("mult_neg_hi", HI, 32'hFFFFFFFF);
    check("mult_neg_lo", LO, 32'hFFFFFFF1);
    run_op(3'b000, 32'h80000000, 32'h80000000);
    check("mult_min_hi", HI, 32'h40000000);
    check("mult_min_lo", LO, 32'h0);
    run_op(3'b010, 32'hFFFFFFF9, 32'd2);
    check("div_neg_lat", lat, 33);
    check("div_neg_lo", LO, 32'hFFFFFFFD);
    check("div_neg_hi", HI, 32'hFFFFFFFF);
    check("div_neg_dbz", DivByZero, 0);
    run_op(3'b011, 32'd7, 32'd2);
    check("divu_lo", LO, 32'd3);
    check("divu_hi", HI, 32'd1);
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
    check("div_wrap_lo", LO, 32'h80000000);
    check("div_wrap_hi", HI, 32'h0);
    check("div_wrap_dbz", DivByZero, 0);
    @(negedge clk);
    start_op(3'b100, 32'h1234, 32'h0);
    check("mthi_hi", HI, 32'h1234);
    check("mthi_busy", Busy, 0);
    check("mthi_done", Done, 0);
    start_op(3'b101, 32'h5678, 32'h0);
    check("mtlo_lo", LO, 32'h5678);
    check("mtlo_busy", Busy, 0);
    run_op(3'b010, 32'd5, 32'd0);
    check("dbz_lat", lat, 33);
    check("dbz_flag", DivByZero, 1);
    check("dbz_hi_kept", HI, 32'h1234);
    check("dbz_lo_kept", LO, 32'h5678);
    @(negedge clk);
    start_op(3'b000, 32'd100, 32'hFFFFFFFE);
    check("mult_clears_dbz", DivByZero, 0);
    repeat (3) @(negedge clk);
    A = 32'd9;
    B = 32'd3;
    MDOp = 3'b011;
    Start = 1'b1;
    @(negedge clk);
    A = 32'hDEAD;
    MDOp = 3'b101;
    @(negedge clk);
    Start = 1'b0;
    MDOp = 3'b111;
    check("mtlo_ignored_busy", LO, 32'h5678);
    check("hi_held_busy", HI, 32'h1234);
    wait_done(lat, bsy);
    check("ign_done", Done, 1);
    check("ign_hi", HI, 32'hFFFFFFFF);
    check("ign_lo", LO, 32'hFFFFFF38);
    start_op(3'b011, 32'd100, 32'd7);
    wait_done(lat, bsy);
    check("b2b_lat", lat, 33);
    check("b2b_lo", LO, 32'd14);
    check("b2b_hi", HI, 32'd2);
    @(negedge clk);
    start_op(3'b010, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_hi", HI, 0);
    check("arst_lo", LO, 0);
    @(negedge clk) rst_n = 1'b1;
    run_op(3'b001, 32'd6, 32'd7);
    check("post_rst_lat", lat, 33);
    check("post_rst_lo", LO, 32'd42);
    check("post_rst_hi", HI, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the EX stage of the MIPS CPU. It sits beside the ALU and takes the same A/B operand buses. It executes MULT, MULTU, DIV and DIVU over multiple cycles, plus single-cycle MTHI and MTLO, and holds the architectural HI/LO registers. The result multiplexer reads HI and LO for MFHI/MFLO, and control stalls the pipeline while Busy is high.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH bits each and the product is 2*WIDTH bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  operand 1: multiplicand, dividend, or MTHI/MTLO source.
- B  input  WIDTH  operand 2: multiplier or divisor.
- MDOp  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
- Start  input  1  request; sampled only in IDLE.
- Busy  output  1  high while a multiply or divide is in progress.
- Done  output  1  one-cycle pulse when HI/LO have just been updated by MULT/MULTU/DIV/DIVU.
- DivByZero  output  1  valid with Done; 1 if the completed DIV/DIVU had B == 0.
- HI  output  WIDTH  architectural HI register.
- LO  output  WIDTH  architectural LO register.

## Operation
- States are IDLE, MUL, DIV and FIN.
- IDLE & Start & MDOp ∈ {MULT, MULTU}:
  - latch |A| and |B| (raw values for MULTU) and the result sign (A[31]^B[31], signed only);
  - clear the counter; go to MUL.
- IDLE & Start & MDOp ∈ {DIV, DIVU}:
  - latch magnitudes, quotient sign (A[31]^B[31]) and remainder sign (A[31]);
  - latch DivByZero = (B == 0); go to DIV.
- IDLE & Start & MTHI: HI <= A at that edge; stay IDLE; no Busy, no Done. MTLO does the same for LO.
- IDLE & Start & no-op MDOp: no effect.
- MUL: one shift-add step per cycle on the 64-bit accumulator. After WIDTH steps go to FIN.
- DIV: one restoring shift-subtract step per cycle. After WIDTH steps go to FIN.
- FIN:
  - apply sign correction: negate the 64-bit product, the quotient and/or the remainder per the latched signs;
  - write {HI,LO} = product, or HI = remainder and LO = quotient;
  - go to IDLE.
- Divide by zero: HI/LO are NOT written, DivByZero = 1, same latency as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (two's-complement wrap, no flag).
- Start while not IDLE is ignored for every MDOp, including MTHI/MTLO; no queueing.
- HI/LO keep their old values throughout MUL/DIV and change only at the FIN edge.
- Async reset (any time, including mid-operation): state = IDLE, counter = 0, HI = LO = 0, Busy = Done = DivByZero = 0. In-flight operation is discarded.

## Timing
- Start accepted at edge E0. Busy = 1 from just after E0 through the cycle ending at edge E(WIDTH+1).
- Iteration edges E1..E(WIDTH); FIN edge E(WIDTH+1), i.e. E33 for WIDTH = 32.
- After E33: Busy = 0, Done = 1 for exactly one cycle, and HI/LO/DivByZero show the new values.
- Latency from Start to Done = 33 cycles for every mul/div, independent of operand values.
- Back-to-back: Start may be asserted in the Done cycle (IDLE) and is accepted at the next edge.
- MTHI/MTLO latency is 1 edge and creates no Busy cycle.
- DivByZero holds its value until the next DIV/DIVU is accepted. It is cleared to 0 when a MULT/MULTU is accepted.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Test plan
- MULTU A = 0xFFFFFFFF, B = 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001; Done exactly 33 cycles after Start; Busy high for 33 cycles.
- MULT A = -3, B = 5 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. Then MULT A = 0x80000000, B = 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV A = -7, B = 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU A = 7, B = 2 -> LO = 3, HI = 1. DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0, DivByZero = 0.
- MTHI A = 0x1234, MTLO A = 0x5678 in idle -> HI/LO updated one edge later, Busy stays 0. Then DIV with B = 0 -> Done after 33 cycles, DivByZero = 1, HI = 0x1234, LO = 0x5678 unchanged.
- Start a MULT, then pulse Start with DIVU and with MTLO while Busy -> both ignored, MULT result correct. Then Start in the Done cycle -> accepted, second Done 33 cycles later.
- Drop rst_n at cycle 10 of a DIV -> Busy, Done, HI and LO go to 0 immediately (asynchronously). After release, MULTU 6 × 7 -> LO = 42, HI = 0.
